// File: rtl/uaddr_seq_if.sv
// -----------------------------------------------------------------------------
// uaddr_seq_if
//
// Bundles the microsequencer's data/control signals between the branch logic /
// control-store side (master) and the sequencer itself (slave).
//
// Signals:
//   UADDR_SEQ_Tipo_InBus        [1:0]        next-address select (00 next,
//                                            01 jump, 10 decode, 11 halt)
//   UADDR_SEQ_JumpAddr_InBus    [ADDR_W-1:0] jump-address field of microword
//   UADDR_SEQ_IR_InBus          [31:0]       instruction register
//   UADDR_SEQ_MemWait_In                     memory not ready, freezes sequencing
//   UADDR_SEQ_CsAddr_OutBus     [ADDR_W-1:0] micro-PC / control-store address
//   UADDR_SEQ_Valid_Out                      current microword may commit
//   UADDR_SEQ_Halted_Out                     sequencer is halted
//   UADDR_SEQ_InstrCount_OutBus [CNT_W-1:0]  decode dispatches taken
//
// Optional (macro UADDR_SEQ_TRAP_EN):
//   UADDR_SEQ_TrapReq_In                     level-sensitive trap request
//   UADDR_SEQ_TrapAck_Out                    one-cycle trap acknowledge
// -----------------------------------------------------------------------------
interface uaddr_seq_if #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 16
);
    logic [1:0]        UADDR_SEQ_Tipo_InBus;
    logic [ADDR_W-1:0] UADDR_SEQ_JumpAddr_InBus;
    logic [31:0]       UADDR_SEQ_IR_InBus;
    logic              UADDR_SEQ_MemWait_In;
    logic [ADDR_W-1:0] UADDR_SEQ_CsAddr_OutBus;
    logic              UADDR_SEQ_Valid_Out;
    logic              UADDR_SEQ_Halted_Out;
    logic [CNT_W-1:0]  UADDR_SEQ_InstrCount_OutBus;
`ifdef UADDR_SEQ_TRAP_EN
    logic              UADDR_SEQ_TrapReq_In;
    logic              UADDR_SEQ_TrapAck_Out;

    modport master (
        output UADDR_SEQ_Tipo_InBus,
        output UADDR_SEQ_JumpAddr_InBus,
        output UADDR_SEQ_IR_InBus,
        output UADDR_SEQ_MemWait_In,
        output UADDR_SEQ_TrapReq_In,
        input  UADDR_SEQ_CsAddr_OutBus,
        input  UADDR_SEQ_Valid_Out,
        input  UADDR_SEQ_Halted_Out,
        input  UADDR_SEQ_InstrCount_OutBus,
        input  UADDR_SEQ_TrapAck_Out
    );

    modport slave (
        input  UADDR_SEQ_Tipo_InBus,
        input  UADDR_SEQ_JumpAddr_InBus,
        input  UADDR_SEQ_IR_InBus,
        input  UADDR_SEQ_MemWait_In,
        input  UADDR_SEQ_TrapReq_In,
        output UADDR_SEQ_CsAddr_OutBus,
        output UADDR_SEQ_Valid_Out,
        output UADDR_SEQ_Halted_Out,
        output UADDR_SEQ_InstrCount_OutBus,
        output UADDR_SEQ_TrapAck_Out
    );
`else
    modport master (
        output UADDR_SEQ_Tipo_InBus,
        output UADDR_SEQ_JumpAddr_InBus,
        output UADDR_SEQ_IR_InBus,
        output UADDR_SEQ_MemWait_In,
        input  UADDR_SEQ_CsAddr_OutBus,
        input  UADDR_SEQ_Valid_Out,
        input  UADDR_SEQ_Halted_Out,
        input  UADDR_SEQ_InstrCount_OutBus
    );

    modport slave (
        input  UADDR_SEQ_Tipo_InBus,
        input  UADDR_SEQ_JumpAddr_InBus,
        input  UADDR_SEQ_IR_InBus,
        input  UADDR_SEQ_MemWait_In,
        output UADDR_SEQ_CsAddr_OutBus,
        output UADDR_SEQ_Valid_Out,
        output UADDR_SEQ_Halted_Out,
        output UADDR_SEQ_InstrCount_OutBus
    );
`endif
endinterface

// File: rtl/uaddr_seq.sv
// -----------------------------------------------------------------------------
// uaddr_seq
//
// Microsequencer stage sitting directly after the branch logic. It owns the
// micro-PC, forms the next control-store address from the 2-bit Tipo select,
// freezes on memory wait, stops on halt and counts decode dispatches.
//
// Ports:
//   UADDR_SEQ_CLOCK_50       in  system clock, rising-edge active
//   UADDR_SEQ_ResetInLow_In  in  asynchronous active-low reset
//   bus                      uaddr_seq_if.slave (Tipo, JumpAddr, IR, MemWait
//                            in; CsAddr, Valid, Halted, InstrCount out)
//
// Parameters:
//   ADDR_W       control-store address width (must be >= 11)
//   CNT_W        decode-dispatch counter width
//   TRAP_VECTOR  microaddress entered on a trap
//
// Optional feature macro: UADDR_SEQ_TRAP_EN
//   Adds TrapReq/TrapAck on the interface. A trap request replaces a decode
//   dispatch (or releases HALT) with a jump to TRAP_VECTOR.
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module uaddr_seq #(
    parameter int                ADDR_W      = 11,
    parameter int                CNT_W       = 16,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR = ADDR_W'(11'h7F0)
) (
    input  logic         UADDR_SEQ_CLOCK_50,
    input  logic         UADDR_SEQ_ResetInLow_In,
    uaddr_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } seqState_t;

    localparam logic [1:0] TIPO_NEXT   = 2'b00;
    localparam logic [1:0] TIPO_JUMP   = 2'b01;
    localparam logic [1:0] TIPO_DECODE = 2'b10;
    localparam logic [1:0] TIPO_HALT   = 2'b11;

    seqState_t         state;
    logic [ADDR_W-1:0] csAddr;
    logic              valid;
    logic              halted;
    logic [CNT_W-1:0]  instrCount;
    logic              trapReq;
    logic              trapAck;

    // Decode entry point: {1, op[1:0], op3[5:0], 00}, zero-extended to the
    // address width. Entry points are four microwords apart.
    function automatic logic [ADDR_W-1:0] decodeAddr(input logic [1:0] op,
                                                     input logic [5:0] op3);
        logic [ADDR_W-1:0] a;
        a       = '0;
        a[10:0] = {1'b1, op, op3, 2'b00};
        return a;
    endfunction

    function automatic logic [ADDR_W-1:0] incAddr(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] incCount(input logic [CNT_W-1:0] c);
        return c + CNT_W'(1);
    endfunction

    // IR bits outside the decode fields are not used by the sequencer.
    logic unusedIrBits;
    assign unusedIrBits = ^{bus.UADDR_SEQ_IR_InBus[29:25], bus.UADDR_SEQ_IR_InBus[18:0]};

`ifdef UADDR_SEQ_TRAP_EN
    assign trapReq                   = bus.UADDR_SEQ_TrapReq_In;
    assign bus.UADDR_SEQ_TrapAck_Out = trapAck;
`else
    // Without the trap feature the request is tied off; the vector and the
    // acknowledge register are kept so the sequencing logic stays identical.
    logic [ADDR_W-1:0] unusedTrapVector;
    logic              unusedTrapAck;
    assign trapReq          = 1'b0;
    assign unusedTrapVector = TRAP_VECTOR;
    assign unusedTrapAck    = trapAck;
`endif

    assign bus.UADDR_SEQ_CsAddr_OutBus     = csAddr;
    assign bus.UADDR_SEQ_Valid_Out         = valid;
    assign bus.UADDR_SEQ_Halted_Out        = halted;
    assign bus.UADDR_SEQ_InstrCount_OutBus = instrCount;

    always_ff @(posedge UADDR_SEQ_CLOCK_50 or negedge UADDR_SEQ_ResetInLow_In) begin
        if (!UADDR_SEQ_ResetInLow_In) begin
            state      <= BOOT;
            csAddr     <= '0;
            valid      <= 1'b0;
            halted     <= 1'b0;
            instrCount <= '0;
            trapAck    <= 1'b0;
        end else begin
            trapAck <= 1'b0;
            case (state)
                BOOT: begin
                    // One dead cycle after reset so the ROM output at
                    // address 0 is settled before the first commit.
                    state <= RUN;
                    valid <= 1'b1;
                end

                RUN, STALL: begin
                    // MemWait wins over Tipo: nothing advances, including
                    // the decode counter.
                    if (bus.UADDR_SEQ_MemWait_In) begin
                        state <= STALL;
                        valid <= 1'b0;
                    end else begin
                        case (bus.UADDR_SEQ_Tipo_InBus)
                            TIPO_NEXT: begin
                                csAddr <= incAddr(csAddr);
                                state  <= RUN;
                                valid  <= 1'b1;
                            end
                            TIPO_JUMP: begin
                                csAddr <= bus.UADDR_SEQ_JumpAddr_InBus;
                                state  <= RUN;
                                valid  <= 1'b1;
                            end
                            TIPO_DECODE: begin
                                state <= RUN;
                                valid <= 1'b1;
                                if (trapReq) begin
                                    // Trap pre-empts the dispatch; the
                                    // instruction is not counted.
                                    csAddr  <= TRAP_VECTOR;
                                    trapAck <= 1'b1;
                                end else begin
                                    csAddr     <= decodeAddr(bus.UADDR_SEQ_IR_InBus[31:30],
                                                             bus.UADDR_SEQ_IR_InBus[24:19]);
                                    instrCount <= incCount(instrCount);
                                end
                            end
                            TIPO_HALT: begin
                                state  <= HALT;
                                valid  <= 1'b0;
                                halted <= 1'b1;
                            end
                            default: begin
                                state <= RUN;
                                valid <= 1'b1;
                            end
                        endcase
                    end
                end

                HALT: begin
                    // Terminal except for a trap, which restarts sequencing
                    // at the trap vector.
                    if (trapReq) begin
                        csAddr  <= TRAP_VECTOR;
                        state   <= RUN;
                        valid   <= 1'b1;
                        halted  <= 1'b0;
                        trapAck <= 1'b1;
                    end
                end

                default: begin
                    state <= BOOT;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uaddr_seq.sv
module tb_uaddr_seq;

    localparam int ADDR_W = 11;
    localparam int CNT_W  = 8;

    logic clk;
    logic rstN;

    uaddr_seq_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    uaddr_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TRAP_VECTOR(11'h7F0)) dut (
        .UADDR_SEQ_CLOCK_50      (clk),
        .UADDR_SEQ_ResetInLow_In (rstN),
        .bus                     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0]      a;
        logic             v;
        logic             h;
        logic [CNT_W-1:0] c;
        logic             k;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Reference model state: 0 BOOT, 1 RUN, 2 STALL, 3 HALT
    int               mState;
    logic [10:0]      mAddr;
    logic             mValid;
    logic             mHalted;
    logic [CNT_W-1:0] mCount;
    logic             mAck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mState = 0; mAddr = '0; mValid = 0; mHalted = 0; mCount = '0; mAck = 0;
    endtask

    task automatic modelStep(input logic [1:0] t, input logic [10:0] j,
                             input logic [31:0] ir, input logic mw, input logic tr);
        mAck = 0;
        case (mState)
            0: begin mState = 1; mValid = 1; end
            1, 2: begin
                if (mw) begin
                    mState = 2; mValid = 0;
                end else if (t == 2'b11) begin
                    mState = 3; mValid = 0; mHalted = 1;
                end else begin
                    mState = 1; mValid = 1;
                    if (t == 2'b00) mAddr = mAddr + 11'd1;
                    else if (t == 2'b01) mAddr = j;
                    else if (tr) begin mAddr = 11'h7F0; mAck = 1; end
                    else begin
                        mAddr  = {1'b1, ir[31:30], ir[24:19], 2'b00};
                        mCount = mCount + 1'b1;
                    end
                end
            end
            default: begin
                if (tr) begin
                    mState = 1; mValid = 1; mHalted = 0; mAddr = 11'h7F0; mAck = 1;
                end
            end
        endcase
    endtask

    task automatic step(input logic [1:0] t, input logic [10:0] j,
                        input logic [31:0] ir, input logic mw, input logic tr);
        exp_t e;
        logic trEff;
        bus.UADDR_SEQ_Tipo_InBus     = t;
        bus.UADDR_SEQ_JumpAddr_InBus = j;
        bus.UADDR_SEQ_IR_InBus       = ir;
        bus.UADDR_SEQ_MemWait_In     = mw;
`ifdef UADDR_SEQ_TRAP_EN
        bus.UADDR_SEQ_TrapReq_In = tr;
        trEff = tr;
`else
        trEff = 1'b0;
`endif
        modelStep(t, j, ir, mw, trEff);
        e = '{a: mAddr, v: mValid, h: mHalted, c: mCount, k: mAck};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("csAddr", 32'(bus.UADDR_SEQ_CsAddr_OutBus), 32'(e.a));
        chk("valid", 32'(bus.UADDR_SEQ_Valid_Out), 32'(e.v));
        chk("halted", 32'(bus.UADDR_SEQ_Halted_Out), 32'(e.h));
        chk("instrCount", 32'(bus.UADDR_SEQ_InstrCount_OutBus), 32'(e.c));
`ifdef UADDR_SEQ_TRAP_EN
        chk("trapAck", 32'(bus.UADDR_SEQ_TrapAck_Out), 32'(e.k));
`endif
    endtask

    // Asserts reset away from the clock edge and checks the asynchronous
    // clear before the next edge arrives.
    task automatic applyReset();
        rstN = 1'b0;
        #2;
        chk("rst_csAddr", 32'(bus.UADDR_SEQ_CsAddr_OutBus), 32'h0);
        chk("rst_valid", 32'(bus.UADDR_SEQ_Valid_Out), 32'h0);
        chk("rst_halted", 32'(bus.UADDR_SEQ_Halted_Out), 32'h0);
        chk("rst_count", 32'(bus.UADDR_SEQ_InstrCount_OutBus), 32'h0);
`ifdef UADDR_SEQ_TRAP_EN
        chk("rst_trapAck", 32'(bus.UADDR_SEQ_TrapAck_Out), 32'h0);
`endif
        modelReset();
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        logic [1:0]  t;
        logic        mw;
        logic        tr;
        rstN = 1'b0;
        bus.UADDR_SEQ_Tipo_InBus     = 2'b00;
        bus.UADDR_SEQ_JumpAddr_InBus = '0;
        bus.UADDR_SEQ_IR_InBus       = '0;
        bus.UADDR_SEQ_MemWait_In     = 1'b0;
`ifdef UADDR_SEQ_TRAP_EN
        bus.UADDR_SEQ_TrapReq_In = 1'b0;
`endif
        @(posedge clk);
        #1;
        applyReset();

        // Boot sequence: 0 (BOOT), 0 (first RUN), then 1, 2, 3
        step(2'b00, 11'h0, 32'h0, 0, 0);
        chk("boot_addr0", 32'(bus.UADDR_SEQ_CsAddr_OutBus), 32'h000);
        chk("boot_valid1", 32'(bus.UADDR_SEQ_Valid_Out), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            step(2'b00, 11'h0, 32'h0, 0, 0);
            chk("seq_addr", 32'(bus.UADDR_SEQ_CsAddr_OutBus), 32'(i));
        end

        // Address wrap and jump
        step(2'b01, 11'h7FF, 32'h0, 0, 0);
        step(2'b00, 11'h0, 32'h0, 0, 0);
        chk("wrap_addr", 32'(bus.UADDR_SEQ_CsAddr_OutBus), 32'h000);
        step(2'b01, 11'h123, 32'h0, 0, 0);
        chk("jump_addr", 32'(bus.UADDR_SEQ_CsAddr_OutBus), 32'h123);

        // Decode: op=10, op3=0 -> {1,10,000000,00} = 0x600; op=00 -> 0x400
        step(2'b10, 11'h0, 32'h8200_4001, 0, 0);
        chk("dec_addr_a", 32'(bus.UADDR_SEQ_CsAddr_OutBus), 32'h600);
        chk("dec_count_a", 32'(bus.UADDR_SEQ_InstrCount_OutBus), 32'h1);
        step(2'b10, 11'h0, 32'h0000_0000, 0, 0);
        chk("dec_addr_b", 32'(bus.UADDR_SEQ_CsAddr_OutBus), 32'h400);
        step(2'b10, 11'h0, 32'h41F8_0000, 0, 0);
        chk("dec_addr_c", 32'(bus.UADDR_SEQ_CsAddr_OutBus), 32'h5FC);

        // Decode under MemWait is not taken and not counted
        step(2'b10, 11'h0, 32'hFFFF_FFFF, 1, 0);
        chk("mw_dec_count", 32'(bus.UADDR_SEQ_InstrCount_OutBus), 32'h3);
        step(2'b00, 11'h0, 32'h0, 0, 0);

        // MemWait for 3 clocks with a pending jump, then release
        for (int i = 0; i < 3; i++) begin
            step(2'b01, 11'h050, 32'h0, 1, 0);
            chk("stall_valid", 32'(bus.UADDR_SEQ_Valid_Out), 32'h0);
        end
        step(2'b01, 11'h050, 32'h0, 0, 0);
        chk("stall_exit_addr", 32'(bus.UADDR_SEQ_CsAddr_OutBus), 32'h050);
        chk("stall_exit_valid", 32'(bus.UADDR_SEQ_Valid_Out), 32'h1);

        // Halt taken on STALL exit
        step(2'b00, 11'h0, 32'h0, 1, 0);
        step(2'b11, 11'h0, 32'h0, 0, 0);
        chk("stall_halt", 32'(bus.UADDR_SEQ_Halted_Out), 32'h1);
        applyReset();

        // Halt at 0x0A4, then inputs are ignored
        step(2'b00, 11'h0, 32'h0, 0, 0);
        step(2'b01, 11'h0A4, 32'h0, 0, 0);
        step(2'b11, 11'h0, 32'h0, 0, 0);
        chk("halt_flag", 32'(bus.UADDR_SEQ_Halted_Out), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(2'(i), 11'h3FF, 32'hFFFF_FFFF, i[0], 0);
            chk("halt_hold", 32'(bus.UADDR_SEQ_CsAddr_OutBus), 32'h0A4);
        end
        applyReset();

        // Counter wrap: 2^CNT_W decodes return the count to 0
        step(2'b00, 11'h0, 32'h0, 0, 0);
        for (int i = 0; i < (1 << CNT_W) - 1; i++) step(2'b10, 11'h0, 32'h0, 0, 0);
        chk("cnt_max", 32'(bus.UADDR_SEQ_InstrCount_OutBus), 32'((1 << CNT_W) - 1));
        step(2'b10, 11'h0, 32'h0, 0, 0);
        chk("cnt_wrap", 32'(bus.UADDR_SEQ_InstrCount_OutBus), 32'h0);

`ifdef UADDR_SEQ_TRAP_EN
        // Trap on a decode, then trap out of HALT
        step(2'b10, 11'h0, 32'h8200_4001, 0, 1);
        chk("trap_addr", 32'(bus.UADDR_SEQ_CsAddr_OutBus), 32'h7F0);
        chk("trap_count", 32'(bus.UADDR_SEQ_InstrCount_OutBus), 32'h0);
        chk("trap_ack", 32'(bus.UADDR_SEQ_TrapAck_Out), 32'h1);
        step(2'b00, 11'h0, 32'h0, 0, 0);
        chk("trap_ack_drop", 32'(bus.UADDR_SEQ_TrapAck_Out), 32'h0);
        step(2'b11, 11'h0, 32'h0, 0, 0);
        step(2'b00, 11'h0, 32'h0, 0, 1);
        chk("halt_trap_addr", 32'(bus.UADDR_SEQ_CsAddr_OutBus), 32'h7F0);
        chk("halt_trap_run", 32'(bus.UADDR_SEQ_Valid_Out), 32'h1);
        chk("halt_trap_halted", 32'(bus.UADDR_SEQ_Halted_Out), 32'h0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            t  = 2'($urandom_range(0, 3));
            if (t == 2'b11 && $urandom_range(0, 5) != 0) t = 2'b00;
            mw = ($urandom_range(0, 3) == 0);
            tr = ($urandom_range(0, 7) == 0);
            step(t, 11'($urandom), 32'($urandom), mw, tr);
            if (mState == 3 && $urandom_range(0, 3) == 0) applyReset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
